// File: rtl/mcast_ptr_ctrl.sv
// Pointer and flag controller for the multicast block buffer.
// One writer, NUM_RD readers, DEPTH = 2**AW blocks, registered flags.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_commit         writer finished one block
//   rd_release[i]     reader i finished one block
//   rd_en_mask[i]     reader i participates in multicast
//   err_clr           clears the sticky error bits
//   wr_ptr            write pointer (AW+1 bits, MSB = wrap bit)
//   rd_ptr            packed read pointers, reader i at [i*(AW+1) +: AW+1]
//   wr_greenflag      writer may commit (no enabled reader full)
//   wr_afull          level >= AFULL_LVL
//   rd_greenflag[i]   reader i enabled and not empty
//   level             max occupancy over enabled readers
//   ovf_err, udf_err  sticky overflow / underflow indications

module mcast_ptr_ctrl #(
    parameter int AW        = 2,
    parameter int NUM_RD    = 2,
    parameter int AFULL_LVL = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_commit,
    input  logic [NUM_RD-1:0]        rd_release,
    input  logic [NUM_RD-1:0]        rd_en_mask,
    input  logic                     err_clr,
    output logic [AW:0]              wr_ptr,
    output logic [NUM_RD*(AW+1)-1:0] rd_ptr,
    output logic                     wr_greenflag,
    output logic                     wr_afull,
    output logic [NUM_RD-1:0]        rd_greenflag,
    output logic [AW:0]              level,
    output logic                     ovf_err,
    output logic                     udf_err
);

    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AFULL_P = PW'(AFULL_LVL);

    // Reset asserts asynchronously but releases two edges after rst_n
    // rises, so the release never races a clock edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    logic [PW-1:0]     rd_ptr_q [NUM_RD];
    logic [PW-1:0]     rd_nxt   [NUM_RD];
    logic [PW-1:0]     occ      [NUM_RD];
    logic [PW-1:0]     wr_nxt;
    logic              wr_acc;
    logic [NUM_RD-1:0] rd_acc;
    logic [NUM_RD-1:0] full_nxt;
    logic [NUM_RD-1:0] rgf_nxt;
    logic [PW-1:0]     lvl_nxt;
    logic              wgf_nxt;
    logic              afull_nxt;
    logic              ovf_set;
    logic              udf_set;

    // Acceptance uses the registered flags; the flags for the next
    // cycle are derived from the next-state pointers so they always
    // match the pointers they are registered alongside.
    always_comb begin
        wr_acc  = wr_commit & wr_greenflag;
        wr_nxt  = wr_ptr + PW'(wr_acc);
        rd_acc  = rd_release & rd_en_mask & rd_greenflag;
        ovf_set = wr_commit & ~wr_greenflag;
        udf_set = |(rd_release & rd_en_mask & ~rd_greenflag);

        full_nxt = '0;
        rgf_nxt  = '0;
        lvl_nxt  = '0;

        for (int i = 0; i < NUM_RD; i++) begin
            // A disabled reader shadows the writer so that on
            // re-enable it starts empty at the current write position.
            if (rd_en_mask[i]) begin
                rd_nxt[i] = rd_ptr_q[i] + PW'(rd_acc[i]);
            end else begin
                rd_nxt[i] = wr_nxt;
            end

            occ[i] = wr_nxt - rd_nxt[i];

            if (rd_en_mask[i]) begin
                full_nxt[i] = (wr_nxt[AW] != rd_nxt[i][AW]) &&
                              (wr_nxt[AW-1:0] == rd_nxt[i][AW-1:0]);
                rgf_nxt[i]  = (occ[i] != '0);
                if (occ[i] > lvl_nxt) begin
                    lvl_nxt = occ[i];
                end
            end
        end

        wgf_nxt   = ~|full_nxt;
        afull_nxt = (lvl_nxt >= AFULL_P);
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr       <= '0;
            wr_greenflag <= 1'b1;
            wr_afull     <= 1'b0;
            rd_greenflag <= '0;
            level        <= '0;
            ovf_err      <= 1'b0;
            udf_err      <= 1'b0;
            for (int i = 0; i < NUM_RD; i++) begin
                rd_ptr_q[i] <= '0;
            end
        end else begin
            wr_ptr       <= wr_nxt;
            wr_greenflag <= wgf_nxt;
            wr_afull     <= afull_nxt;
            rd_greenflag <= rgf_nxt;
            level        <= lvl_nxt;
            // A new violation wins over a clear in the same cycle.
            ovf_err      <= ovf_set | (ovf_err & ~err_clr);
            udf_err      <= udf_set | (udf_err & ~err_clr);
            for (int i = 0; i < NUM_RD; i++) begin
                rd_ptr_q[i] <= rd_nxt[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_out
        assign rd_ptr[g*PW +: PW] = rd_ptr_q[g];
    end

endmodule

// File: doc/mcast_ptr_ctrl.md
Name: mcast_ptr_ctrl

Overview:
Parametrised pointer/flag controller for the multicast block buffer: one writer, NUM_RD independent readers, 2^AW blocks.
Owns the write pointer and one read pointer per reader as registers, advancing them on commit/release strobes.
Produces registered writer-side (~FULL, almost-full, level) and per-reader (~EMPTY) flags.
Supersedes the fixed 2-reader, 4-block combinational flag generator; adds per-reader enable masking, occupancy reporting and sticky error detection.

Parameters:
AW, 2, block index bits; DEPTH = 2^AW blocks; pointers are AW+1 bits (MSB = wrap bit)
NUM_RD, 2, number of reader channels (1..8)
AFULL_LVL, 3, level at or above which wr_afull asserts (1..DEPTH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_commit  in  1  writer finished one block; advance wr_ptr
rd_release  in  NUM_RD  bit i: reader i finished one block; advance rd_ptr_i
rd_en_mask  in  NUM_RD  bit i: reader i participates in multicast
err_clr  in  1  clears sticky error bits
wr_ptr  out  AW+1  write pointer
rd_ptr  out  NUM_RD*(AW+1)  packed read pointers, reader i at bits [i*(AW+1) +: AW+1]
wr_greenflag  out  1  1 = writer may commit (no enabled reader full)
wr_afull  out  1  level >= AFULL_LVL
rd_greenflag  out  NUM_RD  bit i: 1 = reader i has data (enabled and not empty)
level  out  AW+1  max occupancy over enabled readers, 0..DEPTH
ovf_err  out  1  sticky: commit attempted while wr_greenflag=0
udf_err  out  1  sticky: release attempted by an enabled reader whose rd_greenflag=0

Behaviour:
- Reset (async assert, sync release inside the block): wr_ptr=0, all rd_ptr=0, wr_greenflag=1, rd_greenflag=0, level=0, wr_afull=0, ovf_err=0, udf_err=0.
- occ_i = (wr_ptr - rd_ptr_i) mod 2^(AW+1), range 0..DEPTH.
- empty_i: occ_i==0. full_i: MSBs differ and low AW bits equal (occ_i==DEPTH).
- Acceptance at each rising edge uses the registered flags present before that edge:
  - wr_commit accepted iff wr_greenflag=1; wr_ptr <= wr_ptr+1, wrapping mod 2^(AW+1).
  - rd_release[i] accepted iff rd_en_mask[i]=1 and rd_greenflag[i]=1; rd_ptr_i <= rd_ptr_i+1.
- Rejected commit: pointer unchanged, ovf_err <= 1.
- Rejected release from an enabled reader: pointer unchanged, udf_err <= 1. Release from a disabled reader is ignored silently.
- Simultaneous accepted commit and release are both applied in the same edge.
- Disabled reader (rd_en_mask[i]=0): rd_ptr_i <= next wr_ptr every cycle, so it holds occ 0. rd_greenflag[i]=0. Excluded from full and level calculations.
- Re-enable (mask 0->1): reader i starts empty at the current write position and never sees stale blocks.
- All flags and level are registered and computed from next-state pointers and the current rd_en_mask. They are therefore consistent with the pointers in the same cycle: zero extra latency, one cycle from a strobe to its flag effect.
- wr_greenflag = NOR over enabled readers of full_i. It is 1 when no reader is enabled.
- level = max of occ_i over enabled readers, else 0. wr_afull = (level >= AFULL_LVL).
- Sticky errors: set has priority over err_clr in the same cycle. Otherwise err_clr=1 clears both on the next edge.
- rst_n asserted mid-operation: everything returns to reset values immediately. No partial pointer update survives.

Test Plan:
Defaults AW=2, NUM_RD=2, both readers enabled unless stated.
1. Reset: hold rst_n=0, toggle strobes -> wr_ptr=000, rd_ptr=000/000, wr_greenflag=1, rd_greenflag=00, level=0. Release reset -> values unchanged.
2. Fill and overflow: 4 consecutive wr_commit ->
   - after the 3rd: level=3, wr_afull=1, rd_greenflag=11
   - after the 4th: wr_ptr=100, level=4, wr_greenflag=0
   - 5th commit: wr_ptr stays 100, ovf_err=1.
3. Multicast lag: from full, 4 rd_release[0] -> rd_ptr_0=100, rd_greenflag=10, wr_greenflag stays 0. One rd_release[1] -> wr_greenflag=1, level=3.
4. Wrap and simultaneous events: drive to wr_ptr=111, rd_ptr_0=110. Then one cycle with wr_commit plus rd_release[0] -> wr_ptr=000, rd_ptr_0=111, occ_0=1. Two more commits -> wr_ptr=010, level=3 against rd_ptr_0=111.
5. Disable/enable: full with reader1 at 000, deassert rd_en_mask[1] -> next edge rd_ptr_1=wr_ptr=100, rd_greenflag[1]=0, level = occ_0. Re-assert -> reader1 empty; the next commit sets rd_greenflag[1]=1.
6. Underflow and clear: rd_release[0] while rd_greenflag[0]=0 -> rd_ptr_0 unchanged, udf_err=1. err_clr alone -> udf_err=0 next edge. err_clr together with a new violation -> udf_err stays 1.
